// File: rtl/wb_gpio_slave.sv
// Wishbone GPIO slave: LED register, debounced switch/button inputs,
// button rising-edge capture with W1C clear and a level interrupt.
module wb_gpio_slave #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic [3:0]  sw_i,
    input  logic [2:0]  btn_i,
    output logic [7:0]  led_o,
    output logic        irq_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_LED   = 2'd0,
        REG_INPUT = 2'd1,
        REG_EDGE  = 2'd2,
        REG_IRQEN = 2'd3
    } reg_e;

    logic [6:0]    r_sync1;
    logic [6:0]    r_sync2;
    logic [6:0]    r_stable;
    logic [6:0]    w_stable_nxt;
    logic [CW-1:0] r_cnt     [7];
    logic [CW-1:0] w_cnt_nxt [7];

    logic [7:0]    r_led;
    logic [2:0]    r_edge;
    logic [2:0]    r_irq_en;
    logic [2:0]    w_rise;
    logic [2:0]    w_clr;
    logic [2:0]    w_edge_nxt;
    logic          r_ack;
    logic          r_irq;
    logic [31:0]   r_dat;
    logic [31:0]   w_rd_data;
    logic          w_acc;
    logic          w_wr;
    reg_e          w_reg;
    logic          w_unused;

    assign w_unused = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

    // Index 0..3 are switches, 4..6 are buttons, matching the INPUT layout.
    always_comb begin
        w_stable_nxt = r_stable;
        for (int unsigned i = 0; i < 7; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_stable_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge capture uses the next stable value so a rise and a W1C in the
    // same cycle resolve in one register update with set taking priority.
    assign w_rise     = w_stable_nxt[6:4] & ~r_stable[6:4];
    assign w_reg      = reg_e'(wb_adr_i[3:2]);
    assign w_acc      = wb_stb_i & ~r_ack;
    assign w_wr       = w_acc & wb_we_i & wb_sel_i[0];
    assign w_clr      = (w_wr && (w_reg == REG_EDGE)) ? wb_dat_i[6:4] : '0;
    assign w_edge_nxt = (r_edge & ~w_clr) | w_rise;

    always_comb begin
        w_rd_data = '0;
        case (w_reg)
            REG_LED:   w_rd_data[7:0] = r_led;
            REG_INPUT: w_rd_data[6:0] = r_stable;
            REG_EDGE:  w_rd_data[6:4] = r_edge;
            REG_IRQEN: w_rd_data[6:4] = r_irq_en;
            default:   w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int unsigned i = 0; i < 7; i++) begin
                r_cnt[i] <= '0;
            end
            r_led    <= '0;
            r_edge   <= '0;
            r_irq_en <= '0;
            r_ack    <= 1'b0;
            r_irq    <= 1'b0;
            r_dat    <= '0;
        end else begin
            r_sync1  <= {btn_i, sw_i};
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            for (int unsigned i = 0; i < 7; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_ack  <= w_acc;
            r_dat  <= w_acc ? w_rd_data : '0;
            r_irq  <= |(r_edge & r_irq_en);
            r_edge <= w_edge_nxt;
            if (w_wr) begin
                case (w_reg)
                    REG_LED:   r_led    <= wb_dat_i[7:0];
                    REG_IRQEN: r_irq_en <= wb_dat_i[6:4];
                    default:   ;
                endcase
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign led_o    = r_led;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_wb_gpio_slave.sv
// Self-checking bench for wb_gpio_slave (DEBOUNCE_CYCLES=4): directed
// scenarios plus a randomized run against a rule-level reference model.
module tb_wb_gpio_slave;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_ack_o;
    logic [3:0]  sw_i  = '0;
    logic [2:0]  btn_i = '0;
    logic [7:0]  led_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_gpio_slave #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .sw_i(sw_i), .btn_i(btn_i),
        .led_o(led_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Reference model. hist[j] holds the input value captured j+1 edges ago;
    // a bit's stable level flips once the last DB synchronized samples all
    // disagree with it.
    logic [6:0]  hist [0:DB] = '{default: '0};
    logic [7:0]  m_led    = '0;
    logic [2:0]  m_edge   = '0;
    logic [2:0]  m_irqen  = '0;
    logic        m_irq    = 1'b0;
    logic        m_ack    = 1'b0;
    logic [31:0] m_dat    = '0;
    logic [6:0]  m_stable = '0;
    logic [6:0]  mn_stable;
    logic [2:0]  mn_clr;
    logic        m_acc;
    logic        m_flip;

    always @(posedge clk) begin
        if (rst) begin
            m_led = '0; m_edge = '0; m_irqen = '0; m_irq = 1'b0;
            m_ack = 1'b0; m_dat = '0; m_stable = '0;
            for (int j = 0; j <= DB; j++) hist[j] = '0;
        end else begin
            mn_stable = m_stable;
            for (int b = 0; b < 7; b++) begin
                m_flip = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (hist[j][b] == m_stable[b]) m_flip = 1'b0;
                if (m_flip) mn_stable[b] = ~m_stable[b];
            end
            m_acc = wb_stb_i && !m_ack;
            m_dat = 0;
            if (m_acc) begin
                case (wb_adr_i[3:2])
                    2'd0: m_dat = {24'h0, m_led};
                    2'd1: m_dat = {25'h0, m_stable};
                    2'd2: m_dat = {25'h0, m_edge, 4'h0};
                    default: m_dat = {25'h0, m_irqen, 4'h0};
                endcase
            end
            m_irq  = |(m_edge & m_irqen);
            mn_clr = 3'b000;
            if (m_acc && wb_we_i && wb_sel_i[0]) begin
                if (wb_adr_i[3:2] == 2'd0) m_led = wb_dat_i[7:0];
                if (wb_adr_i[3:2] == 2'd3) m_irqen = wb_dat_i[6:4];
                if (wb_adr_i[3:2] == 2'd2) mn_clr = wb_dat_i[6:4];
            end
            m_edge   = (m_edge & ~mn_clr) | (mn_stable[6:4] & ~m_stable[6:4]);
            m_stable = mn_stable;
            m_ack    = m_acc;
            for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = {btn_i, sw_i};
        end
    end

    // Called at a negedge; returns one idle cycle after the ack cycle.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic ack, output logic [31:0] rdat);
        wb_adr_i = (adr & 32'hC) | ($urandom & 32'hFFFF_FFF3);
        wb_dat_i = dat;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_stb_i = 1'b1;
        @(negedge clk);
        ack  = wb_ack_o;
        rdat = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic        ack;
        logic [31:0] rd;
        rst = 1'b1; sw_i = '0; btn_i = '0;
        wb_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", wb_ack_o); end
        n_cmp++; if (wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat got %h want 0", wb_dat_o); end
        n_cmp++; if (led_o !== 8'h00) begin n_bad++; $display("FAIL reset_led got %h want 00", led_o); end
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq_o); end
        wb_stb_i = 1'b0;
        rst = 1'b0;
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL first_stb_ack got %b want 1", ack); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_input got %h want 0", rd); end
    endtask

    task automatic test_write_read();
        logic        ack;
        logic [31:0] rd;
        wb_xfer(1'b1, 32'h0, 32'h0000_00A5, 4'hF, ack, rd);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL wr_ack got %b want 1", ack); end
        n_cmp++; if (led_o !== 8'hA5) begin n_bad++; $display("FAIL wr_led got %h want a5", led_o); end
        wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack got %b want 1", ack); end
        n_cmp++; if (rd !== 32'h0000_00A5) begin n_bad++; $display("FAIL rd_led got %h want 000000a5", rd); end
        n_cmp++; if (wb_dat_o !== 32'h0 || wb_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL rd_idle got dat=%h ack=%b want 0/0", wb_dat_o, wb_ack_o); end
    endtask

    task automatic test_masked_write();
        logic        ack;
        logic [31:0] rd;
        wb_xfer(1'b1, 32'h0, 32'h0000_00FF, 4'hE, ack, rd);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL masked_ack got %b want 1", ack); end
        n_cmp++; if (led_o !== 8'hA5) begin n_bad++; $display("FAIL masked_led got %h want a5", led_o); end
        wb_xfer(1'b1, 32'h4, 32'h0000_007F, 4'hF, ack, rd);
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL input_ro got %h want 0", rd); end
    endtask

    task automatic test_debounce();
        logic        ack;
        logic [31:0] rd;
        sw_i = 4'b1010;
        repeat (6) @(negedge clk);
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (rd !== 32'h0000_000A) begin n_bad++; $display("FAIL debounce_level got %h want 0000000a", rd); end
        sw_i = 4'b1011;
        repeat (3) @(negedge clk);
        sw_i = 4'b1010;
        repeat (8) @(negedge clk);
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (rd !== 32'h0000_000A) begin n_bad++; $display("FAIL debounce_glitch got %h want 0000000a", rd); end
    endtask

    task automatic test_edge_irq();
        logic        ack;
        logic [31:0] rd;
        wb_xfer(1'b1, 32'hC, 32'h0000_0010, 4'h1, ack, rd);
        btn_i = 3'b001;
        repeat (6) @(negedge clk);
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_early got %b want 0", irq_o); end
        @(negedge clk);
        n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL irq_set got %b want 1", irq_o); end
        wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (rd !== 32'h0000_0010) begin n_bad++; $display("FAIL edge_set got %h want 00000010", rd); end
        wb_xfer(1'b1, 32'h8, 32'h0000_0010, 4'hF, ack, rd);
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_clear got %b want 0", irq_o); end
        wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL edge_w1c got %h want 0", rd); end
    endtask

    task automatic test_set_beats_clear();
        logic        ack;
        logic [31:0] rd;
        btn_i = 3'b011;
        repeat (5) @(negedge clk);
        wb_xfer(1'b1, 32'h8, 32'h0000_0020, 4'hF, ack, rd);
        wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (rd !== 32'h0000_0020) begin n_bad++; $display("FAIL set_beats_clear got %h want 00000020", rd); end
    endtask

    task automatic test_back_to_back();
        logic want;
        wb_adr_i = 32'h0; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_stb_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            want = (i % 2 == 1);
            n_cmp++; if (wb_ack_o !== want || wb_ack_o !== m_ack) begin
                n_bad++; $display("FAIL b2b_ack[%0d] got %b want %b", i + 1, wb_ack_o, want); end
        end
        wb_stb_i = 1'b0;
        @(negedge clk);
        // Reset lands on the very edge that would acknowledge the write.
        wb_adr_i = 32'h0; wb_dat_i = 32'h5A; wb_we_i = 1'b1; wb_sel_i = 4'hF;
        wb_stb_i = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL abort_ack got %b want 0", wb_ack_o); end
        wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (led_o !== 8'h00 || wb_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL abort_led got led=%h ack=%b want 00/0", led_o, wb_ack_o); end
    endtask

    task automatic test_reset_held_btn();
        logic        ack;
        logic [31:0] rd;
        sw_i = '0; btn_i = 3'b001; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL held_btn_edge0 got %h want 0", rd); end
        repeat (5) @(negedge clk);
        wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, ack, rd);
        n_cmp++; if (rd !== 32'h0000_0010) begin n_bad++; $display("FAIL held_btn_rise got %h want 00000010", rd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) sw_i  = 4'($urandom);
            if ($urandom_range(5) == 0) btn_i = 3'($urandom);
            wb_stb_i = 1'($urandom);
            wb_we_i  = 1'($urandom);
            wb_adr_i = $urandom;
            wb_dat_i = $urandom;
            wb_sel_i = 4'($urandom);
            @(negedge clk);
            n_cmp++; if (wb_ack_o !== m_ack || wb_dat_o !== m_dat) begin
                n_bad++; $display("FAIL rand_bus[%0d] got ack=%b dat=%h want ack=%b dat=%h",
                                  i, wb_ack_o, wb_dat_o, m_ack, m_dat); end
            n_cmp++; if (led_o !== m_led || irq_o !== m_irq) begin
                n_bad++; $display("FAIL rand_out[%0d] got led=%h irq=%b want led=%h irq=%b",
                                  i, led_o, irq_o, m_led, m_irq); end
        end
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_masked_write();
        test_debounce();
        test_edge_irq();
        test_set_beats_clear();
        test_back_to_back();
        test_reset_held_btn();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
